// File: rtl/mc_responder.sv
// In-order memory-side responder: queues load/store requests and services them against a 64-bit scratchpad.
// Optional build macro MC_RSP_STALL_INJECT_EN adds LFSR-driven pseudo-random request stalls.
module mc_responder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16,
  parameter int LAT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mc_req_ld,
  input  logic        mc_req_st,
  input  logic [47:0] mc_req_vadr,
  input  logic [63:0] mc_req_wrd_rdctl,
  output logic        mc_rd_rq_stall,
  output logic        mc_wr_rq_stall,
  output logic        mc_rsp_push,
  output logic [31:0] mc_rsp_rdctl,
  output logic [63:0] mc_rsp_data,
  input  logic        mc_rsp_stall,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int QW = 1 + ADDR_W + 64;
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 2);
  localparam logic [CW-1:0] ONE    = CW'(1);

  // Handshake: a request is taken on every edge where ld|st is high (stall is
  // advisory, one cycle late); a response is transferred on every edge where
  // mc_rsp_push is high, and push is never raised while mc_rsp_stall is high.

  logic [QW-1:0]     q_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [63:0]       mem [WORDS];

  logic              req;
  logic              full;
  logic              acc;
  logic              advance;
  logic              pop;
  logic              pop_ld;
  logic              pop_st;
  logic [QW-1:0]     head;
  logic              head_st;
  logic [ADDR_W-1:0] head_idx;
  logic [63:0]       head_wd;
  logic              inj;

  logic [LAT-1:0]    sv;
  logic [31:0]       stag [LAT];
  logic [63:0]       sdat [LAT];

  logic              unused_vadr;
  assign unused_vadr = ^{mc_req_vadr[47:ADDR_W+3], mc_req_vadr[2:0]};

  always_comb begin
    req      = mc_req_ld | mc_req_st;
    full     = (count == FULL);
    acc      = req & ~full;
    advance  = ~mc_rsp_stall;
    pop      = (count != '0) & advance;
    head     = q_mem[rd_ptr];
    head_st  = head[QW-1];
    head_idx = head[64 +: ADDR_W];
    head_wd  = head[63:0];
    pop_ld   = pop & ~head_st;
    pop_st   = pop & head_st;
  end

  always_comb begin
    count_nxt = count;
    case ({acc, pop})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Queue payload needs no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (acc) q_mem[wr_ptr] <= {mc_req_st, mc_req_vadr[ADDR_W+2:3], mc_req_wrd_rdctl};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if ((mc_req_ld & mc_req_st) | (req & full)) err <= 1'b1;
    end
  end

  // A store written this cycle is seen by a load popped on any later cycle;
  // a same-cycle read can only belong to the store itself and is discarded.
  always_ff @(posedge clk) begin
    if (pop_st) mem[head_idx] <= head_wd;
    if (advance) begin
      sdat[0] <= mem[head_idx];
      stag[0] <= head_wd[31:0];
      for (int i = 1; i < LAT; i++) begin
        sdat[i] <= sdat[i-1];
        stag[i] <= stag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sv <= '0;
    end else if (advance) begin
      sv[0] <= pop_ld;
      for (int i = 1; i < LAT; i++) sv[i] <= sv[i-1];
    end
  end

`ifdef MC_RSP_STALL_INJECT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // The seed has bit 0 set, so gate with reset to keep stalls low while held.
  assign inj = lfsr[0] & reset_n;
`else
  assign inj = 1'b0;
`endif

  always_comb begin
    mc_rd_rq_stall = (count >= ALMOST) | inj;
    mc_wr_rq_stall = (count >= ALMOST) | inj;
    mc_rsp_push    = sv[LAT-1] & ~mc_rsp_stall;
    mc_rsp_rdctl   = sv[LAT-1] ? stag[LAT-1] : '0;
    mc_rsp_data    = sv[LAT-1] ? sdat[LAT-1] : '0;
  end

endmodule

// File: tb/tb_mc_responder.sv
// Scoreboard bench for mc_responder: directed request vectors, expected responses queued at issue.
module tb_mc_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mc_req_ld = 1'b0;
  logic        mc_req_st = 1'b0;
  logic [47:0] mc_req_vadr = '0;
  logic [63:0] mc_req_wrd_rdctl = '0;
  logic        mc_rd_rq_stall;
  logic        mc_wr_rq_stall;
  logic        mc_rsp_push;
  logic [31:0] mc_rsp_rdctl;
  logic [63:0] mc_rsp_data;
  logic        mc_rsp_stall = 1'b0;
  logic        err;

  mc_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mc_req_ld        (mc_req_ld),
    .mc_req_st        (mc_req_st),
    .mc_req_vadr      (mc_req_vadr),
    .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
    .mc_rd_rq_stall   (mc_rd_rq_stall),
    .mc_wr_rq_stall   (mc_wr_rq_stall),
    .mc_rsp_push      (mc_rsp_push),
    .mc_rsp_rdctl     (mc_rsp_rdctl),
    .mc_rsp_data      (mc_rsp_data),
    .mc_rsp_stall     (mc_rsp_stall),
    .err              (err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [95:0] exp_q[$];
  logic [63:0] model [0:1023];
  int push_count = 0;
  int last_push_cyc = -1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: pops the expected queue on every response
  always @(negedge clk) begin
    if (mc_rsp_push === 1'b1) begin
      push_count++;
      last_push_cyc = cyc;
      check("push_during_stall", mc_rsp_stall, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push actual=rdctl %h data %h required=no response", mc_rsp_rdctl, mc_rsp_data);
      end else begin
        check("rsp_tag_data", {mc_rsp_rdctl, mc_rsp_data}, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic set_req(input logic ld, input logic st, input logic [47:0] va,
                         input logic [63:0] wd, input bit exp_rsp);
    mc_req_ld = ld;
    mc_req_st = st;
    mc_req_vadr = va;
    mc_req_wrd_rdctl = wd;
    if (st) model[va[12:3]] = wd;
    if (exp_rsp) exp_q.push_back({wd[31:0], model[va[12:3]]});
  endtask

  task automatic issue(input logic ld, input logic st, input logic [47:0] va,
                       input logic [63:0] wd, input bit exp_rsp);
    set_req(ld, st, va, wd, exp_rsp);
    @(posedge clk); #1;
    mc_req_ld = 1'b0;
    mc_req_st = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0, issued, k;
    logic s;

    repeat (3) @(posedge clk);
    #1;
    check("reset_push", mc_rsp_push, 1'b0);
    check("reset_stalls", {mc_rd_rq_stall, mc_wr_rq_stall}, 2'b00);
    check("reset_err", err, 1'b0);
    check("reset_rsp_bus", {mc_rsp_rdctl, mc_rsp_data}, 96'h0);
    reset_n = 1'b1;
    idle(1);

    for (int i = 0; i < 32; i++)
      issue(1'b0, 1'b1, 48'(i * 8), 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h1_0001), 1'b0);
    idle(5);

    // store then load the same word, fixed latency
    p0 = push_count;
    c0 = cyc;
    issue(1'b0, 1'b1, 48'h40, 64'hDEAD_BEEF_0000_0001, 1'b0);
    issue(1'b1, 1'b0, 48'h40, 64'h5, 1'b1);
    idle(10);
    check("raw_push_count", push_count, p0 + 1);
    check("raw_push_cycle", last_push_cyc, c0 + 6);

    // fill under response stall, respecting request stall one cycle late
    mc_rsp_stall = 1'b1;
    p0 = push_count;
    issued = 0;
    s = mc_rd_rq_stall;
    for (int j = 0; j < 25; j++) begin
      if (!s) begin
        set_req(1'b1, 1'b0, 48'((issued % 32) * 8), 64'(32'h100 + issued), 1'b1);
        issued++;
      end
      @(negedge clk);
      s = mc_rd_rq_stall;
      @(posedge clk); #1;
      mc_req_ld = 1'b0;
    end
    check("fill_issued", issued, 15);
    check("fill_stalls", {mc_rd_rq_stall, mc_wr_rq_stall}, 2'b11);
    check("fill_err", err, 1'b0);
    check("fill_no_push", push_count, p0);
    mc_rsp_stall = 1'b0;
    wait_drain(60);
    check("fill_drain_count", push_count, p0 + 15);

    // response stall toggling during a 32-load stream
    p0 = push_count;
    issued = 0;
    k = 0;
    s = mc_rd_rq_stall;
    while (issued < 32 && k < 200) begin
      mc_rsp_stall = k[0];
      if (!s) begin
        set_req(1'b1, 1'b0, 48'((issued % 32) * 8), 64'(32'h200 + issued), 1'b1);
        issued++;
      end
      @(negedge clk);
      s = mc_rd_rq_stall;
      @(posedge clk); #1;
      mc_req_ld = 1'b0;
      k++;
    end
    mc_rsp_stall = 1'b0;
    check("toggle_issued", issued, 32);
    wait_drain(100);
    idle(6);
    check("toggle_push_count", push_count, p0 + 32);

    // simultaneous load and store: store wins, error latches
    p0 = push_count;
    issue(1'b1, 1'b1, 48'h140, 64'hFACE_0000_0000_0028, 1'b0);
    idle(2);
    check("illegal_err", err, 1'b1);
    issue(1'b1, 1'b0, 48'h140, 64'h77, 1'b1);
    wait_drain(20);
    idle(4);
    check("illegal_push_count", push_count, p0 + 1);
    check("illegal_err_sticky", err, 1'b1);

    // address aliasing modulo scratchpad size
    issue(1'b0, 1'b1, 48'h2000, 64'h1234, 1'b0);
    issue(1'b1, 1'b0, 48'h0, 64'h99, 1'b1);
    check("alias_expect", exp_q[exp_q.size()-1], {32'h99, 64'h1234});
    wait_drain(20);
    idle(2);

    // reset with loads queued
    mc_rsp_stall = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 48'(i * 8), 64'(32'h400 + i), 1'b1);
    idle(2);
    p0 = push_count;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", {mc_rsp_push, mc_rd_rq_stall, mc_wr_rq_stall, err}, 4'b0000);
    check("rst_mid_rsp_bus", {mc_rsp_rdctl, mc_rsp_data}, 96'h0);
    exp_q.delete();
    mc_rsp_stall = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(20);
    check("rst_mid_no_rsp", push_count, p0);

    // overflow: 17 requests into a 16-entry queue that cannot drain
    mc_rsp_stall = 1'b1;
    p0 = push_count;
    for (int i = 0; i < 17; i++) issue(1'b1, 1'b0, 48'(i * 8), 64'(32'h300 + i), i < 16);
    idle(1);
    check("ovf_err", err, 1'b1);
    check("ovf_no_push", push_count, p0);
    mc_rsp_stall = 1'b0;
    wait_drain(80);
    idle(6);
    check("ovf_push_count", push_count, p0 + 16);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
